// File: rtl/serial_transmitter.sv
// Parallel-in, serial-out transmitter: accepts a word on valid/ready and sends it LSB-first with a per-bit shift strobe.
// Optional even-parity trailer bit is enabled by defining SERIAL_TRANSMITTER_PARITY_EN.
module serial_transmitter #(
  parameter int bitwidth   = 16,
  parameter int bit_cycles = 1
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [bitwidth-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                serial_out,
  output logic                shift_out,
  output logic                busy,
  output logic                frame_done
);

  localparam int BCW = $clog2(bitwidth + 1);
  localparam int DCW = $clog2(bit_cycles + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(bitwidth - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(bit_cycles - 1);
  localparam logic [DCW-1:0] DIV_ONE  = DCW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef SERIAL_TRANSMITTER_PARITY_EN
    ST_PARITY = 2'd2,
`endif
    ST_DONE   = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [bitwidth-1:0]   shreg_r, shreg_s;
  logic [BCW-1:0]        bit_cnt_r, bit_cnt_s;
  logic [DCW-1:0]        div_cnt_r, div_cnt_s;
  logic                  out_bit_s, in_frame_s, strobe_s;
  logic                  serial_out_r, shift_out_r, busy_r, frame_done_r, data_ready_r;

`ifdef SERIAL_TRANSMITTER_PARITY_EN
  logic                  parity_r, parity_s;

  function automatic logic even_parity(input logic [bitwidth-1:0] word);
    return ^word;
  endfunction
`endif

  // Next-state and next-output computation; outputs are registered from these values.
  always_comb begin
    state_s   = state_r;
    shreg_s   = shreg_r;
    bit_cnt_s = bit_cnt_r;
    div_cnt_s = div_cnt_r;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
    parity_s  = parity_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (data_valid && data_ready_r) begin
          state_s   = ST_SHIFT;
          shreg_s   = data_in;
          bit_cnt_s = {BCW{1'b0}};
          div_cnt_s = {DCW{1'b0}};
`ifdef SERIAL_TRANSMITTER_PARITY_EN
          parity_s  = even_parity(data_in);
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (div_cnt_r == DIV_LAST) begin
          shreg_s   = {1'b0, shreg_r[bitwidth-1:1]};
          bit_cnt_s = bit_cnt_r + BIT_ONE;
          div_cnt_s = {DCW{1'b0}};
          if (bit_cnt_r == BIT_LAST) begin
`ifdef SERIAL_TRANSMITTER_PARITY_EN
            state_s = ST_PARITY;
`else
            state_s = ST_DONE;
`endif
          end else begin
            state_s = ST_SHIFT;
          end
        end else begin
          div_cnt_s = div_cnt_r + DIV_ONE;
        end
      end
`ifdef SERIAL_TRANSMITTER_PARITY_EN
      ST_PARITY: begin
        if (div_cnt_r == DIV_LAST) begin
          div_cnt_s = {DCW{1'b0}};
          state_s   = ST_DONE;
        end else begin
          div_cnt_s = div_cnt_r + DIV_ONE;
        end
      end
`endif
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    case (state_s)
      ST_SHIFT:  out_bit_s = shreg_s[0];
`ifdef SERIAL_TRANSMITTER_PARITY_EN
      ST_PARITY: out_bit_s = parity_s;
`endif
      default:   out_bit_s = 1'b0;
    endcase

`ifdef SERIAL_TRANSMITTER_PARITY_EN
    in_frame_s = (state_s == ST_SHIFT) || (state_s == ST_PARITY);
`else
    in_frame_s = (state_s == ST_SHIFT);
`endif
    strobe_s = in_frame_s && (div_cnt_s == DIV_LAST);
  end

  // State, datapath and registered outputs; clear abandons any frame in flight.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r      <= ST_IDLE;
      shreg_r      <= {bitwidth{1'b0}};
      bit_cnt_r    <= {BCW{1'b0}};
      div_cnt_r    <= {DCW{1'b0}};
`ifdef SERIAL_TRANSMITTER_PARITY_EN
      parity_r     <= 1'b0;
`endif
      serial_out_r <= 1'b0;
      shift_out_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      data_ready_r <= 1'b1;
    end else begin
      state_r      <= state_s;
      shreg_r      <= shreg_s;
      bit_cnt_r    <= bit_cnt_s;
      div_cnt_r    <= div_cnt_s;
`ifdef SERIAL_TRANSMITTER_PARITY_EN
      parity_r     <= parity_s;
`endif
      serial_out_r <= out_bit_s;
      shift_out_r  <= strobe_s;
      busy_r       <= in_frame_s;
      frame_done_r <= (state_s == ST_DONE);
      data_ready_r <= (state_s == ST_IDLE);
    end
  end

  assign data_ready = data_ready_r;
  assign serial_out = serial_out_r;
  assign shift_out  = shift_out_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_serial_transmitter.sv
// Self-checking bench for serial_transmitter: two instances (bit_cycles 1 and 4) checked cycle by cycle
// against a frame model derived from the word, the bit period and the optional parity bit.
module tb_serial_transmitter;

`ifdef SERIAL_TRANSMITTER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W = 16;
  localparam int F = W + PAR;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [15:0] din [2];
  logic [1:0]  valid = 2'b00;
  logic [1:0]  rdy, ser, sh, bsy, fd;

  int vectors = 0;
  int miscompares = 0;

  serial_transmitter #(.bitwidth(16), .bit_cycles(1)) dut1 (
    .clock(clock), .clear(clear), .data_in(din[0]), .data_valid(valid[0]),
    .data_ready(rdy[0]), .serial_out(ser[0]), .shift_out(sh[0]), .busy(bsy[0]), .frame_done(fd[0])
  );

  serial_transmitter #(.bitwidth(16), .bit_cycles(4)) dut4 (
    .clock(clock), .clear(clear), .data_in(din[1]), .data_valid(valid[1]),
    .data_ready(rdy[1]), .serial_out(ser[1]), .shift_out(sh[1]), .busy(bsy[1]), .frame_done(fd[1])
  );

  always #5 clock = ~clock;

  function automatic int bc_of(input int inst);
    return (inst == 0) ? 1 : 4;
  endfunction

  // Compare {ready, serial, shift, busy, done} of one instance against expectations.
  task automatic cmp_outs(input string name, input int inst, input logic [4:0] exp);
    logic [4:0] act;
    act = {rdy[inst], ser[inst], sh[inst], bsy[inst], fd[inst]};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d t=%0t {rdy,ser,sh,busy,done} got %b expected %b", name, inst, $time, act, exp);
    end
  endtask

  // Offer a word while the block is idle; accept happens at the next rising edge.
  task automatic start_frame(input int inst, input logic [15:0] word);
    @(negedge clock);
    cmp_outs("idle_before_accept", inst, 5'b10000);
    din[inst]   = word;
    valid[inst] = 1'b1;
    @(posedge clock);
  endtask

  // Check every cycle of a frame from cycle 1 after accept to the frame_done cycle, plus the received word.
  task automatic expect_frame(input string name, input int inst, input logic [15:0] word,
                              input bit hold, input logic [15:0] hold_word);
    int         bc, total, k, strobes;
    logic       e_ser, e_sh, e_busy, e_fd;
    logic [16:0] rx;
    logic [15:0] rx_word;
    bc = bc_of(inst);
    total = F * bc;
    strobes = 0;
    rx = 17'd0;
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clock);
      if (c == 1) begin
        if (hold) begin
          din[inst] = hold_word;
        end else begin
          valid[inst] = 1'b0;
          din[inst]   = 16'($urandom);
        end
      end
      if (c <= total) begin
        k      = (c - 1) / bc;
        e_ser  = (k < W) ? word[k] : ^word;
        e_sh   = ((c % bc) == 0);
        e_busy = 1'b1;
        e_fd   = 1'b0;
      end else begin
        e_ser = 1'b0; e_sh = 1'b0; e_busy = 1'b0; e_fd = 1'b1;
      end
      cmp_outs(name, inst, {1'b0, e_ser, e_sh, e_busy, e_fd});
      if (sh[inst] === 1'b1) begin
        strobes++;
        rx = {ser[inst], rx[16:1]};
      end
    end
    rx_word = (PAR == 1) ? rx[15:0] : rx[16:1];
    vectors++;
    if (strobes != F || rx_word !== word || (PAR == 1 && rx[16] !== ^word)) begin
      miscompares++;
      $display("FAIL %s_rx inst%0d got word %h strobes %0d expected word %h strobes %0d",
               name, inst, rx_word, strobes, word, F);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    din[0] = 16'h0000;
    din[1] = 16'h0000;
    repeat (2) @(negedge clock);
    cmp_outs("reset", 0, 5'b10000);
    cmp_outs("reset", 1, 5'b10000);
    clear = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      din[0] = 16'($urandom);
      cmp_outs("idle_no_valid", 0, 5'b10000);
    end
  endtask

  task automatic test_directed();
    start_frame(0, 16'hA5C3);
    expect_frame("frame_a5c3", 0, 16'hA5C3, 1'b0, 16'h0000);
    start_frame(1, 16'h8001);
    expect_frame("frame_8001_bc4", 1, 16'h8001, 1'b0, 16'h0000);
    start_frame(0, 16'h0007);
    expect_frame("frame_0007", 0, 16'h0007, 1'b0, 16'h0000);
    start_frame(0, 16'h0003);
    expect_frame("frame_0003", 0, 16'h0003, 1'b0, 16'h0000);
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      start_frame(0, w);
      expect_frame("random_bc1", 0, w, 1'b0, 16'h0000);
    end
    for (int i = 0; i < 5; i++) begin
      w = 16'($urandom);
      start_frame(1, w);
      expect_frame("random_bc4", 1, w, 1'b0, 16'h0000);
    end
  endtask

  task automatic test_back_to_back();
    start_frame(0, 16'hC0DE);
    expect_frame("b2b_first", 0, 16'hC0DE, 1'b1, 16'h1234);
    @(negedge clock);
    cmp_outs("b2b_idle_gap", 0, 5'b10000);
    @(posedge clock);
    expect_frame("b2b_second", 0, 16'h1234, 1'b0, 16'h0000);
  endtask

  task automatic test_clear_midframe();
    start_frame(0, 16'hFFFF);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      if (c == 1) valid[0] = 1'b0;
      cmp_outs("pre_clear_bit", 0, 5'b01110);
    end
    @(negedge clock);
    clear = 1'b1;
    #1;
    cmp_outs("clear_midframe", 0, 5'b10000);
    @(negedge clock);
    clear = 1'b0;
    start_frame(0, 16'h0001);
    expect_frame("after_clear", 0, 16'h0001, 1'b0, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_directed();
    test_random();
    test_back_to_back();
    test_clear_midframe();
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
